// File: rtl/axi4_lite_write_regfile_if.sv
// AXI4-Lite write-channel bundle (AW, W, B) between the interconnect and
// the register-file slave. Signal names carry the direction as seen from
// the slave.
interface axi4_lite_write_regfile_if #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_SIZE  = 32
);
    logic [ADDR_WIDTH-1:0]    write_address_i;
    logic                     write_address_valid_i;
    logic                     write_address_ready_o;
    logic [DATA_SIZE-1:0]     write_data_i;
    logic [DATA_SIZE/8-1:0]   write_data_strb_i;
    logic                     write_data_valid_i;
    logic                     write_data_ready_o;
    logic [1:0]               write_response_o;
    logic                     write_response_valid_o;
    logic                     write_response_ready_i;

    modport master (
        output write_address_i, write_address_valid_i,
        input  write_address_ready_o,
        output write_data_i, write_data_strb_i, write_data_valid_i,
        input  write_data_ready_o,
        input  write_response_o, write_response_valid_o,
        output write_response_ready_i
    );

    modport slave (
        input  write_address_i, write_address_valid_i,
        output write_address_ready_o,
        input  write_data_i, write_data_strb_i, write_data_valid_i,
        output write_data_ready_o,
        output write_response_o, write_response_valid_o,
        input  write_response_ready_i
    );
endinterface

// File: rtl/axi4_lite_write_regfile.sv
// AXI4-Lite write slave with a byte-strobed register file. AW and W are
// captured independently into one-entry holding registers; once both are
// held the write is decoded (DECERR / SLVERR / OKAY) and committed in a
// single cycle, then the response is offered on B until accepted.
module axi4_lite_write_regfile #(
    parameter int               DEPTH      = 4,
    parameter int               DATA_SIZE  = 32,
    parameter int               ADDR_WIDTH = $clog2(DEPTH*DATA_SIZE/8) + 1,
    parameter logic [DEPTH-1:0] RO_MASK    = '0
) (
    input  logic                         clk_i,
    input  logic                         rst_clk_i,
    axi4_lite_write_regfile_if.slave     bus,
    output logic [DEPTH*DATA_SIZE-1:0]   registers_o,
    output logic                         write_event_o,
    output logic [$clog2(DEPTH)-1:0]     write_index_o,
    output logic [DATA_SIZE/8-1:0]       write_enable_o
);
    localparam int NB    = DATA_SIZE / 8;
    localparam int OFF   = $clog2(NB);
    localparam int IDX_W = $clog2(DEPTH);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [ADDR_WIDTH-1:0] DEPTH_A = ADDR_WIDTH'(DEPTH);

    // One-hot: each state owns exactly one flop.
    typedef enum logic [2:0] {
        ST_COLLECT  = 3'b001,
        ST_COMMIT   = 3'b010,
        ST_RESPONSE = 3'b100
    } state_t;

    // Response code for a captured address; the first matching rule wins.
    function automatic logic [1:0] decode_resp(input logic [ADDR_WIDTH-1:0] addr);
        logic [ADDR_WIDTH-1:0] word;
        logic [IDX_W-1:0]      idx;
        word = addr >> OFF;
        idx  = IDX_W'(word);
        if (word >= DEPTH_A) begin
            decode_resp = RESP_DECERR;
        end else if (addr[OFF-1:0] != {OFF{1'b0}}) begin
            decode_resp = RESP_SLVERR;
        end else if (RO_MASK[idx]) begin
            decode_resp = RESP_SLVERR;
        end else begin
            decode_resp = RESP_OKAY;
        end
    endfunction

    // Byte-lane merge: strobed lanes take new data, the rest keep old data.
    function automatic logic [DATA_SIZE-1:0] merge_bytes(
        input logic [DATA_SIZE-1:0] old_v,
        input logic [DATA_SIZE-1:0] new_v,
        input logic [NB-1:0]        strb
    );
        logic [DATA_SIZE-1:0] res;
        res = old_v;
        for (int k = 0; k < NB; k++) begin
            if (strb[k]) begin
                res[k*8 +: 8] = new_v[k*8 +: 8];
            end else begin
                res[k*8 +: 8] = old_v[k*8 +: 8];
            end
        end
        return res;
    endfunction

    state_t                 state_q;
    logic                   aw_full_q;
    logic                   w_full_q;
    logic [ADDR_WIDTH-1:0]  addr_q;
    logic [DATA_SIZE-1:0]   data_q;
    logic [NB-1:0]          strb_q;
    logic                   aw_ready_q;
    logic                   w_ready_q;
    logic                   bvalid_q;
    logic [1:0]             resp_q;
    logic                   event_q;
    logic [IDX_W-1:0]       index_q;
    logic [NB-1:0]          enable_q;
    logic [DATA_SIZE-1:0]   regs_q [DEPTH];

    logic                   aw_hs_s;
    logic                   w_hs_s;
    logic                   aw_full_d;
    logic                   w_full_d;
    logic [IDX_W-1:0]       word_idx_s;
    logic [1:0]             resp_d;
    logic [DATA_SIZE-1:0]   merged_d;

    // Handshakes, next-cycle holding state, and decode of the held write.
    always_comb begin
        aw_hs_s    = aw_ready_q & bus.write_address_valid_i;
        w_hs_s     = w_ready_q & bus.write_data_valid_i;
        aw_full_d  = aw_full_q | aw_hs_s;
        w_full_d   = w_full_q | w_hs_s;
        word_idx_s = IDX_W'(addr_q >> OFF);
        resp_d     = decode_resp(addr_q);
        merged_d   = merge_bytes(regs_q[word_idx_s], data_q, strb_q);
    end

    // Control FSM with holding registers, register file and registered outputs.
    always_ff @(posedge clk_i) begin
        if (rst_clk_i) begin
            state_q    <= ST_COLLECT;
            aw_full_q  <= 1'b0;
            w_full_q   <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            strb_q     <= '0;
            aw_ready_q <= 1'b0;
            w_ready_q  <= 1'b0;
            bvalid_q   <= 1'b0;
            resp_q     <= RESP_OKAY;
            event_q    <= 1'b0;
            index_q    <= '0;
            enable_q   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            event_q <= 1'b0;
            case (state_q)
                ST_COLLECT: begin
                    if (aw_hs_s) begin
                        addr_q    <= bus.write_address_i;
                        aw_full_q <= 1'b1;
                    end
                    if (w_hs_s) begin
                        data_q   <= bus.write_data_i;
                        strb_q   <= bus.write_data_strb_i;
                        w_full_q <= 1'b1;
                    end
                    // Counting this cycle's handshakes lets a same-cycle AW+W
                    // reach COMMIT without a wasted cycle.
                    if (aw_full_d && w_full_d) begin
                        state_q    <= ST_COMMIT;
                        aw_ready_q <= 1'b0;
                        w_ready_q  <= 1'b0;
                    end else begin
                        aw_ready_q <= ~aw_full_d;
                        w_ready_q  <= ~w_full_d;
                    end
                end
                ST_COMMIT: begin
                    resp_q   <= resp_d;
                    bvalid_q <= 1'b1;
                    state_q  <= ST_RESPONSE;
                    if (resp_d == RESP_OKAY) begin
                        regs_q[word_idx_s] <= merged_d;
                        event_q            <= 1'b1;
                        index_q            <= word_idx_s;
                        enable_q           <= strb_q;
                    end
                end
                ST_RESPONSE: begin
                    if (bus.write_response_ready_i) begin
                        bvalid_q   <= 1'b0;
                        aw_full_q  <= 1'b0;
                        w_full_q   <= 1'b0;
                        aw_ready_q <= 1'b1;
                        w_ready_q  <= 1'b1;
                        state_q    <= ST_COLLECT;
                    end
                end
                default: begin
                    state_q    <= ST_COLLECT;
                    aw_full_q  <= 1'b0;
                    w_full_q   <= 1'b0;
                    aw_ready_q <= 1'b0;
                    w_ready_q  <= 1'b0;
                    bvalid_q   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.write_address_ready_o  = aw_ready_q;
    assign bus.write_data_ready_o     = w_ready_q;
    assign bus.write_response_o       = resp_q;
    assign bus.write_response_valid_o = bvalid_q;
    assign write_event_o              = event_q;
    assign write_index_o              = index_q;
    assign write_enable_o             = enable_q;

    for (genvar g = 0; g < DEPTH; g++) begin : g_flat
        assign registers_o[g*DATA_SIZE +: DATA_SIZE] = regs_q[g];
    end
endmodule

// File: tb/tb_axi4_lite_write_regfile.sv
// Directed bench for axi4_lite_write_regfile (DEPTH=4, DATA_SIZE=32,
// register 0 read-only). Inputs are driven and outputs sampled 1ns after
// each rising edge.
module tb_axi4_lite_write_regfile;
    logic         clk;
    logic         rst;
    logic [127:0] regs;
    logic         wevt;
    logic [1:0]   widx;
    logic [3:0]   wen;
    int           n_tests;
    int           n_fail;

    axi4_lite_write_regfile_if #(.ADDR_WIDTH(5), .DATA_SIZE(32)) bus ();

    axi4_lite_write_regfile #(
        .DEPTH(4), .DATA_SIZE(32), .ADDR_WIDTH(5), .RO_MASK(4'b0001)
    ) dut (
        .clk_i          (clk),
        .rst_clk_i      (rst),
        .bus            (bus),
        .registers_o    (regs),
        .write_event_o  (wevt),
        .write_index_o  (widx),
        .write_enable_o (wen)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Same-cycle AW+W write, checked through COMMIT and RESPONSE, accepted at once.
    task automatic write_txn(input string tag, input logic [4:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input logic [1:0] exp_resp,
                             input logic [127:0] exp_regs, input logic exp_evt,
                             input logic [1:0] exp_idx, input logic [3:0] exp_en);
        check_eq({tag, ".aw_rdy_in"}, bus.write_address_ready_o, 1'b1);
        check_eq({tag, ".w_rdy_in"}, bus.write_data_ready_o, 1'b1);
        bus.write_address_i       = addr;
        bus.write_address_valid_i = 1'b1;
        bus.write_data_i          = data;
        bus.write_data_strb_i     = strb;
        bus.write_data_valid_i    = 1'b1;
        tick();
        bus.write_address_valid_i = 1'b0;
        bus.write_data_valid_i    = 1'b0;
        check_eq({tag, ".commit_rdy"}, {bus.write_address_ready_o, bus.write_data_ready_o}, 2'b00);
        check_eq({tag, ".commit_bv"}, bus.write_response_valid_o, 1'b0);
        tick();
        check_eq({tag, ".bvalid"}, bus.write_response_valid_o, 1'b1);
        check_eq({tag, ".resp"}, bus.write_response_o, exp_resp);
        check_eq({tag, ".regs"}, regs, exp_regs);
        check_eq({tag, ".event"}, wevt, exp_evt);
        if (exp_evt) begin
            check_eq({tag, ".index"}, widx, exp_idx);
            check_eq({tag, ".enable"}, wen, exp_en);
        end
        bus.write_response_ready_i = 1'b1;
        tick();
        bus.write_response_ready_i = 1'b0;
        check_eq({tag, ".bv_done"}, bus.write_response_valid_o, 1'b0);
        check_eq({tag, ".evt_done"}, wevt, 1'b0);
        check_eq({tag, ".rdy_back"}, {bus.write_address_ready_o, bus.write_data_ready_o}, 2'b11);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst = 1'b1;
        bus.write_address_i        = 5'h00;
        bus.write_address_valid_i  = 1'b0;
        bus.write_data_i           = 32'h0;
        bus.write_data_strb_i      = 4'h0;
        bus.write_data_valid_i     = 1'b0;
        bus.write_response_ready_i = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst.rdy", {bus.write_address_ready_o, bus.write_data_ready_o}, 2'b00);
        check_eq("rst.bvalid", bus.write_response_valid_o, 1'b0);
        check_eq("rst.resp", bus.write_response_o, 2'b00);
        check_eq("rst.regs", regs, 128'h0);
        check_eq("rst.evt", {wevt, widx, wen}, 7'h00);
        rst = 1'b0;
        check_eq("rel.rdy0", {bus.write_address_ready_o, bus.write_data_ready_o}, 2'b00);
        tick();
        check_eq("rel.rdy1", {bus.write_address_ready_o, bus.write_data_ready_o}, 2'b11);
        check_eq("rel.bvalid", bus.write_response_valid_o, 1'b0);

        // Same-cycle full-word write to register 1
        write_txn("t1", 5'h04, 32'hDEADBEEF, 4'hF, 2'b00,
                  128'h00000000_00000000_DEADBEEF_00000000, 1'b1, 2'd1, 4'hF);
        // Preload register 2 so the partial write below shows preserved bytes
        write_txn("t2pre", 5'h08, 32'h11223344, 4'hF, 2'b00,
                  128'h00000000_11223344_DEADBEEF_00000000, 1'b1, 2'd2, 4'hF);

        // W arrives three cycles ahead of AW
        bus.write_data_i       = 32'h000000AA;
        bus.write_data_strb_i  = 4'h1;
        bus.write_data_valid_i = 1'b1;
        tick();
        bus.write_data_valid_i = 1'b0;
        check_eq("t2.wait_w0", bus.write_data_ready_o, 1'b0);
        check_eq("t2.wait_aw0", bus.write_address_ready_o, 1'b1);
        tick();
        check_eq("t2.wait_w1", bus.write_data_ready_o, 1'b0);
        tick();
        check_eq("t2.wait_w2", bus.write_data_ready_o, 1'b0);
        check_eq("t2.wait_bv", bus.write_response_valid_o, 1'b0);
        bus.write_address_i       = 5'h08;
        bus.write_address_valid_i = 1'b1;
        tick();
        bus.write_address_valid_i = 1'b0;
        check_eq("t2.commit_rdy", {bus.write_address_ready_o, bus.write_data_ready_o}, 2'b00);
        check_eq("t2.commit_bv", bus.write_response_valid_o, 1'b0);
        tick();
        check_eq("t2.bvalid", bus.write_response_valid_o, 1'b1);
        check_eq("t2.resp", bus.write_response_o, 2'b00);
        check_eq("t2.regs", regs, 128'h00000000_112233AA_DEADBEEF_00000000);
        check_eq("t2.evt", {wevt, widx, wen}, {1'b1, 2'd2, 4'h1});
        bus.write_response_ready_i = 1'b1;
        tick();
        bus.write_response_ready_i = 1'b0;
        check_eq("t2.rdy_back", {bus.write_address_ready_o, bus.write_data_ready_o}, 2'b11);

        // Error responses leave the file untouched
        write_txn("decerr", 5'h10, 32'h99999999, 4'hF, 2'b11,
                  128'h00000000_112233AA_DEADBEEF_00000000, 1'b0, 2'd0, 4'h0);
        write_txn("unalign", 5'h06, 32'h99999999, 4'hF, 2'b10,
                  128'h00000000_112233AA_DEADBEEF_00000000, 1'b0, 2'd0, 4'h0);
        write_txn("ro", 5'h00, 32'h99999999, 4'hF, 2'b10,
                  128'h00000000_112233AA_DEADBEEF_00000000, 1'b0, 2'd0, 4'h0);

        // OKAY with no strobes: event with zero enables, data unchanged
        write_txn("nostrb", 5'h04, 32'hFFFFFFFF, 4'h0, 2'b00,
                  128'h00000000_112233AA_DEADBEEF_00000000, 1'b1, 2'd1, 4'h0);

        // B back-pressure for 5 cycles
        bus.write_address_i       = 5'h0C;
        bus.write_address_valid_i = 1'b1;
        bus.write_data_i          = 32'hCAFEF00D;
        bus.write_data_strb_i     = 4'hF;
        bus.write_data_valid_i    = 1'b1;
        tick();
        bus.write_address_valid_i = 1'b0;
        bus.write_data_valid_i    = 1'b0;
        tick();
        check_eq("bp.regs", regs, 128'hCAFEF00D_112233AA_DEADBEEF_00000000);
        for (int i = 0; i < 5; i++) begin
            check_eq("bp.bvalid", bus.write_response_valid_o, 1'b1);
            check_eq("bp.resp", bus.write_response_o, 2'b00);
            check_eq("bp.rdy", {bus.write_address_ready_o, bus.write_data_ready_o}, 2'b00);
            tick();
        end
        check_eq("bp.evt_once", wevt, 1'b0);
        bus.write_response_ready_i = 1'b1;
        tick();
        bus.write_response_ready_i = 1'b0;
        check_eq("bp.bv_done", bus.write_response_valid_o, 1'b0);
        check_eq("bp.rdy_back", {bus.write_address_ready_o, bus.write_data_ready_o}, 2'b11);

        // Reset asserted during COMMIT
        bus.write_address_i       = 5'h08;
        bus.write_address_valid_i = 1'b1;
        bus.write_data_i          = 32'h55555555;
        bus.write_data_strb_i     = 4'hF;
        bus.write_data_valid_i    = 1'b1;
        tick();
        bus.write_address_valid_i = 1'b0;
        bus.write_data_valid_i    = 1'b0;
        rst = 1'b1;
        tick();
        check_eq("mrst.regs", regs, 128'h0);
        check_eq("mrst.bvalid", bus.write_response_valid_o, 1'b0);
        check_eq("mrst.evt", wevt, 1'b0);
        rst = 1'b0;
        tick();
        check_eq("mrst.bvalid2", bus.write_response_valid_o, 1'b0);
        check_eq("mrst.rdy", {bus.write_address_ready_o, bus.write_data_ready_o}, 2'b11);
        write_txn("post", 5'h04, 32'h12345678, 4'hF, 2'b00,
                  128'h00000000_00000000_12345678_00000000, 1'b1, 2'd1, 4'hF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/axi4_lite_write_regfile.md
# axi4_lite_write_regfile

AXI4-Lite write-channel slave with an integrated byte-strobed register file, the next generation of our single-beat write front end. Address and data channels are decoupled: each has its own one-entry holding register, so AW and W may arrive in either order or together. Each transaction is decoded into OKAY, SLVERR or DECERR, and a read-only mask protects selected registers. It sits between the AXI4-Lite interconnect and peripheral control logic, which consumes the flattened register contents and a one-cycle write-event strobe.

## Interface
- DEPTH, 4: number of registers; must be 2 or more.
- DATA_SIZE, 32: register and bus width in bits; must be 32 or 64.
- ADDR_WIDTH, $clog2(DEPTH*DATA_SIZE/8)+1: byte-address width. The extra bit makes out-of-range addresses reachable.
- RO_MASK, '0: DEPTH bits; bit i set makes register i read-only.
- clk_i  in  1  sole clock; all logic on the rising edge.
- rst_clk_i  in  1  reset, synchronous and active-high.
- write_address_i  in  ADDR_WIDTH  AW byte address.
- write_address_valid_i  in  1  AW valid.
- write_address_ready_o  out  1  AW ready.
- write_data_i  in  DATA_SIZE  W data.
- write_data_strb_i  in  DATA_SIZE/8  W byte strobes.
- write_data_valid_i  in  1  W valid.
- write_data_ready_o  out  1  W ready.
- write_response_o  out  2  B response: OKAY=00, SLVERR=10, DECERR=11.
- write_response_valid_o  out  1  B valid.
- write_response_ready_i  in  1  B ready.
- registers_o  out  DEPTH*DATA_SIZE  register file contents; register i occupies bits [i*DATA_SIZE +: DATA_SIZE].
- write_event_o  out  1  one-cycle pulse when a register is updated.
- write_index_o  out  $clog2(DEPTH)  index of the register updated; meaningful only when write_event_o is high.
- write_enable_o  out  DATA_SIZE/8  strobes applied by the update; meaningful only when write_event_o is high.

## Operation
- Holding registers: aw_full (with the captured address) and w_full (with the captured data and strobes). Both are cleared on reset.
- State machine, one-hot encoded:
  - COLLECT: write_address_ready_o = !aw_full; write_data_ready_o = !w_full.
    - An AW handshake captures the address and sets aw_full; a W handshake captures data and strobes and sets w_full.
    - Go to COMMIT at the edge where both will be full, counting handshakes in the current cycle.
  - COMMIT: both readies low; lasts exactly one cycle.
    - Decode and register update happen here; the response code is latched.
    - Then go to RESPONSE.
  - RESPONSE: write_response_valid_o = 1; write_response_o holds the latched code.
    - On write_response_ready_i, clear aw_full and w_full, drop B valid and go to COLLECT.
- Decode of the captured address a, with index = a >> $clog2(DATA_SIZE/8). First match wins:
  1. index >= DEPTH: DECERR.
  2. a not aligned to DATA_SIZE/8: SLVERR.
  3. RO_MASK[index] set: SLVERR.
  4. Otherwise: OKAY.
- Update happens only for OKAY: for each strobe bit k that is set, byte k of register index takes byte k of the data. write_event_o pulses with write_index_o and write_enable_o.
  - An OKAY write with all strobes zero still pulses write_event_o, with enables 0, and leaves data unchanged.
- Error responses leave registers_o unchanged and do not pulse write_event_o.

## Timing
- Outputs while rst_clk_i is high and on the first edge after release: readies 0, B valid 0, write_response_o 00, registers_o all 0, write_event_o 0, write_index_o 0, write_enable_o 0.
- Readies are driven from flops; the first ready-high cycle is the cycle after reset deasserts.
- AW and W in the same cycle: both captured; COMMIT in the next cycle; B valid in the cycle after that; registers_o shows the new value in the same cycle B valid rises.
- AW and W in different cycles: the earlier channel's ready drops after its handshake; the later channel's handshake edge is the reference point for the latency above.
- B held with ready low: B valid, write_response_o and all holding state stay stable; both readies stay 0.
- After B is accepted, readies return high in the next cycle. Minimum spacing is 3 cycles per transaction.
- Reset asserted mid-transaction, in any state: the transaction is discarded, registers are cleared and the state returns to COLLECT. No B is issued for the discarded transaction.
- Valid inputs are never required to be held once the handshake completes.

## Test plan
- Reset with DEPTH=4, DATA_SIZE=32: all outputs 0; the readies rise one cycle after release.
- AW=0x4 and W=0xDEADBEEF with strb=0xF, both in the same cycle -> COMMIT next cycle, then B=OKAY; register 1 = 0xDEADBEEF; write_event_o pulses with index 1 and enables 0xF.
- W (0x000000AA, strb=0x1) three cycles before AW=0x8 -> W ready low while waiting; register 2 byte 0 = 0xAA, other bytes unchanged; B=OKAY.
- AW=0x10 -> B=DECERR. AW=0x6 -> B=SLVERR. With RO_MASK=4'b0001, AW=0x0 -> B=SLVERR. In all three cases registers_o is unchanged and write_event_o stays low.
- B ready held low for 5 cycles -> B valid and response stable, AW/W readies stay 0; accepting B restores the readies next cycle.
- Reset pulsed during COMMIT -> no B is issued, registers are cleared, and the next transaction completes normally.
